rf_writeback_queue: RTL and testbench

//  Write-side feeder for the 32x32 register file. Accepts writeback requests
//  (rd, data) from the execute/memory side over a valid/ready handshake.

---
 rtl/rf_writeback_queue.sv | 101 ++++++++++
 tb/tb_rf_writeback_queue.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO feeding the register file write port, one drain per cycle,
// with youngest-entry bypass lookup for the two decode source indices.
module rf_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_rd,
  input  logic [XLEN-1:0]            in_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_rd,
  output logic [XLEN-1:0]            rf_din,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  output logic                       rs1_hit,
  output logic [XLEN-1:0]            rs1_fwd,
  output logic                       rs2_hit,
  output logic [XLEN-1:0]            rs2_fwd,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [DEPTH-1:0] valid_q;
  logic [4:0]      ent_rd_q   [DEPTH];
  logic [XLEN-1:0] ent_data_q [DEPTH];

  logic push, pop;

  assign in_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

  // rd==0 completes the handshake but is dropped here.
  assign push = in_valid && in_ready && (in_rd != 5'd0);
  assign pop  = !empty;

  // Head is not presented while reset is held so a discarded entry never reaches the file.
  assign rf_we  = pop && !reset;
  assign rf_rd  = rf_we ? ent_rd_q[rd_ptr_q]   : 5'd0;
  assign rf_din = rf_we ? ent_data_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= in_rd;
      ent_data_q[wr_ptr_q] <= in_data;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    rs1_hit = 1'b0;
    rs1_fwd = '0;
    rs2_hit = 1'b0;
    rs2_fwd = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && (rs1 != 5'd0) && (ent_rd_q[idx] == rs1)) begin
        rs1_hit = 1'b1;
        rs1_fwd = ent_data_q[idx];
      end
      if (valid_q[idx] && (rs2 != 5'd0) && (ent_rd_q[idx] == rs2)) begin
        rs2_hit = 1'b1;
        rs2_fwd = ent_data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed plus random stimulus for rf_writeback_queue, checked against a queue-based
// model of the writeback FIFO and the register file it feeds.
module tb_rf_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_din;
  logic [4:0]      rs1, rs2;
  logic            rs1_hit, rs2_hit;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [2:0]      count;
  logic            empty;

  rf_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din),
    .rs1(rs1), .rs2(rs2),
    .rs1_hit(rs1_hit), .rs1_fwd(rs1_fwd), .rs2_hit(rs2_hit), .rs2_fwd(rs2_fwd),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            q[$];
  logic [XLEN-1:0] model_rf [32];
  logic [XLEN-1:0] seen_rf  [32];
  int              checks   = 0;
  int              failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [4:0] rs, output logic hit, output logic [XLEN-1:0] val);
    hit = 1'b0;
    val = '0;
    if (rs != 5'd0) begin
      foreach (q[i]) begin
        if (q[i].rd == rs) begin
          hit = 1'b1;
          val = q[i].data;
        end
      end
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, advance the model just after posedge.
  task automatic step(input logic rst, input logic v, input logic [4:0] rd,
                      input logic [XLEN-1:0] d, input logic [4:0] s1, input logic [4:0] s2);
    int              n;
    logic            e_we, h1, h2;
    logic [XLEN-1:0] f1, f2;
    @(negedge clk);
    reset = rst; in_valid = v; in_rd = rd; in_data = d; rs1 = s1; rs2 = s2;
    #1;
    n    = q.size();
    e_we = (n != 0) && !rst;
    lookup(s1, h1, f1);
    lookup(s2, h2, f2);
    chk("in_ready", in_ready, n != DEPTH);
    chk("empty", empty, n == 0);
    chk("count", count, n);
    chk("rf_we", rf_we, e_we);
    chk("rf_rd", rf_rd, e_we ? q[0].rd : 5'd0);
    chk("rf_din", rf_din, e_we ? q[0].data : '0);
    chk("rs1_hit", rs1_hit, h1);
    chk("rs1_fwd", rs1_fwd, f1);
    chk("rs2_hit", rs2_hit, h2);
    chk("rs2_fwd", rs2_fwd, f2);
    if (rf_we === 1'b1) seen_rf[rf_rd] = rf_din;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (n != 0) begin
        model_rf[q[0].rd] = q[0].data;
        void'(q.pop_front());
      end
      if (v && (n != DEPTH) && (rd != 5'd0)) q.push_back('{rd: rd, data: d});
    end
  endtask

  task automatic idle(input int cycles, input logic [4:0] s1, input logic [4:0] s2);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 5'd0, '0, s1, s2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      seen_rf[i]  = '0;
    end
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Idle after reset.
    idle(10, 5'd0, 5'd0);

    // Single push, then forward and drain.
    step(1'b0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
    idle(2, 5'd5, 5'd5);

    // Back-to-back pushes of rd 1..4 then continuous pushes.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 5'(8 + i), 32'h200 + 32'(i), 5'(8 + i), 5'd9);
    idle(2, 5'd0, 5'd0);

    // Consecutive pushes with a held request interleaved.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'(16 + i), 32'h300 + 32'(i), 5'd17, 5'd18);
    step(1'b0, 1'b1, 5'd20, 32'hCAFE, 5'd20, 5'd16);
    idle(2, 5'd20, 5'd0);

    // Same rd twice; youngest wins and file ends with the later value.
    step(1'b0, 1'b1, 5'd7, 32'hA, 5'd0, 5'd7);
    step(1'b0, 1'b1, 5'd7, 32'hB, 5'd0, 5'd7);
    idle(2, 5'd0, 5'd7);
    chk("rf7_final", seen_rf[7], 32'hB);

    // rd==0 is accepted but never queued.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);

    // Reset with an entry queued discards it.
    step(1'b0, 1'b1, 5'd3, 32'hDEAD, 5'd3, 5'd0);
    step(1'b1, 1'b1, 5'd4, 32'hBEEF, 5'd3, 5'd4);
    idle(3, 5'd3, 5'd4);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end
    idle(3, 5'd0, 5'd0);

    for (int i = 0; i < 32; i++) chk("rf_contents", seen_rf[i], model_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
